// File: rtl/arith_pkg.sv
// Shared arithmetic package: serial subtractor FSM states and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit counter width for a WIDTH-bit serial datapath (counts 0..WIDTH-1).
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub3_full_sub_cell.sv
// Combinational one-bit full subtractor: diff = a - b - bin, with borrow-out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub3.sv
// Bit-serial subtractor d = a - b, LSB first, one full-subtractor cell and a borrow flop.
// Define SERIAL_SUB_SAT_EN to clamp d to 0 when the final borrow is set.
module serial_sub3
  import arith_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             bw_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] result_d;

  full_sub_cell u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (bw_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // Each new difference bit enters at the MSB so the LSB-first stream lands in place.
  assign res_d = {cell_diff, res_q[WIDTH-1:1]};
  assign cnt_d = cnt_q + CW'(1);

`ifdef SERIAL_SUB_SAT_EN
  assign result_d = bw_q ? '0 : res_q;
`else
  assign result_d = res_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          res_q <= res_d;
          bw_q  <= cell_bout;
          cnt_q <= cnt_d;
          if (cnt_q == LAST_BIT) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Results commit here so the done pulse and the new d/borrow appear together.
          d_q      <= result_d;
          borrow_q <= bw_q;
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign d      = d_q;
  assign borrow = borrow_q;

endmodule
